// File: rtl/param_ram_pkg.sv
// Shared types and helpers for the parametrised data RAM.
package ram_pkg;

    typedef logic [0:0] state_t;

    localparam state_t CLEAR = 1'b0;
    localparam state_t RUN   = 1'b1;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Never returns less than 1 so a DEPTH of 1 still gets a real counter bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_ram_if.sv
// Request/response bundle between a load/store unit and the data RAM.
interface param_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BE_W = ram_pkg::be_width(DATA_W);

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              err;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_be,
        input  req_ready, rd_valid, rd_data, err, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_be,
        output req_ready, rd_valid, rd_data, err, busy
    );

endinterface

// File: rtl/param_ram_core.sv
// Storage array with byte-lane writes and a registered read port; one access per cycle.
// No reset: contents and read register are only defined once written.
module param_ram_core
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic                        i_clk,
    input  logic                        i_en,
    input  logic                        i_we,
    input  logic [IDX_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [be_width(DATA_W)-1:0] i_be,
    output logic [DATA_W-1:0]           o_rdata
);

    localparam int BE_W = be_width(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/param_ram.sv
// Single-port word-addressed data RAM: optional zero-fill after reset, range check, 1/2-cycle reads.
// No response backpressure; req_ready is low only during the post-reset clear.
module param_ram
    import ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH          = 32,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    param_ram_if.slave  io_bus
);

    localparam int             BE_W      = be_width(DATA_W);
    localparam int             IDX_W     = clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam state_t         RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

    state_t            r_state;
    logic [IDX_W-1:0]  r_clr_cnt;

    logic              w_clearing;
    logic              w_accept;
    logic              w_in_range;
    logic              w_rd_acc;

    logic              w_mem_en;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [BE_W-1:0]   w_mem_be;
    logic [DATA_W-1:0] w_core_rdata;

    logic              r_rv1;
    logic              r_err1;
    logic              r_zero;
    logic [DATA_W-1:0] w_rd_data1;

    assign w_clearing       = (r_state == CLEAR);
    assign io_bus.req_ready = !w_clearing;
    assign io_bus.busy      = w_clearing;

    assign w_accept   = io_bus.req_valid & io_bus.req_ready;
    assign w_in_range = ({1'b0, io_bus.req_addr} < DEPTH_C);
    assign w_rd_acc   = w_accept & !io_bus.req_wr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= RST_STATE;
            r_clr_cnt <= '0;
        end else if (w_clearing) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (r_clr_cnt == LAST_IDX) begin
                r_state <= RUN;
            end
        end
    end

    // Clear owns the port while it runs; out-of-range requests never reach the array.
    assign w_mem_en    = w_clearing | (w_accept & w_in_range);
    assign w_mem_we    = w_clearing | io_bus.req_wr;
    assign w_mem_addr  = w_clearing ? r_clr_cnt : io_bus.req_addr[IDX_W-1:0];
    assign w_mem_wdata = w_clearing ? '0 : io_bus.req_wdata;
    assign w_mem_be    = w_clearing ? '1 : io_bus.req_be;

    param_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .i_clk   (i_clk),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .i_be    (w_mem_be),
        .o_rdata (w_core_rdata)
    );

    // r_zero masks the unreset core register until the first in-range read, and after any
    // out-of-range read, so rd_data reads 0 and holds it between pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rv1  <= 1'b0;
            r_err1 <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_rv1  <= w_rd_acc;
            r_err1 <= w_accept & !w_in_range;
            if (w_rd_acc) begin
                r_zero <= !w_in_range;
            end
        end
    end

    assign w_rd_data1 = r_zero ? '0 : w_core_rdata;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              r_rv2;
            logic              r_err2;
            logic [DATA_W-1:0] r_rd_data2;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_rv2      <= 1'b0;
                    r_err2     <= 1'b0;
                    r_rd_data2 <= '0;
                end else begin
                    r_rv2  <= r_rv1;
                    r_err2 <= r_err1;
                    if (r_rv1) begin
                        r_rd_data2 <= w_rd_data1;
                    end
                end
            end

            assign io_bus.rd_valid = r_rv2;
            assign io_bus.err      = r_err2;
            assign io_bus.rd_data  = r_rd_data2;
        end else begin : g_lat1
            assign io_bus.rd_valid = r_rv1;
            assign io_bus.err      = r_err1;
            assign io_bus.rd_data  = w_rd_data1;
        end
    endgenerate

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench: one READ_LAT=1 and one READ_LAT=2 instance driven with identical requests.
`timescale 1ns/1ps
module tb_param_ram;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    param_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    param_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    param_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .i_clk (clk), .i_rst (rst), .io_bus (bus1)
    );
    param_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_dut2 (
        .i_clk (clk), .i_rst (rst), .io_bus (bus2)
    );

    typedef struct {
        int          due;
        bit          rv;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] mem [DEPTH];
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;
    int          checks = 0;
    int          errors = 0;
    int          edges = 0;
    int          clr_edges = 0;
    exp_t        h1, h2;
    bit          have1, have2;

    always @(posedge clk) begin
        edges++;
        if (rst) clr_edges = 0;
        else     clr_edges++;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edges);
        end
    endfunction

    task automatic mon(input string nm, input logic rv, input logic [31:0] d, input logic e,
                       input bit have, input exp_t h, inout logic [31:0] last);
        if (have) begin
            chk({nm, "_rd_valid"}, {31'b0, rv}, {31'b0, h.rv});
            chk({nm, "_err"}, {31'b0, e}, {31'b0, h.err});
            if (h.rv) last = h.data;
        end else begin
            chk({nm, "_rd_valid_idle"}, {31'b0, rv}, 32'd0);
            chk({nm, "_err_idle"}, {31'b0, e}, 32'd0);
        end
        chk({nm, "_rd_data"}, d, last);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_rd_valid1", {31'b0, bus1.rd_valid}, 32'd0);
            chk("rst_rd_valid2", {31'b0, bus2.rd_valid}, 32'd0);
            chk("rst_err1", {31'b0, bus1.err}, 32'd0);
            chk("rst_err2", {31'b0, bus2.err}, 32'd0);
            chk("rst_rd_data1", bus1.rd_data, 32'd0);
            chk("rst_rd_data2", bus2.rd_data, 32'd0);
            chk("rst_busy1", {31'b0, bus1.busy}, 32'd1);
            chk("rst_ready1", {31'b0, bus1.req_ready}, 32'd0);
        end else begin
            chk("req_ready1", {31'b0, bus1.req_ready}, {31'b0, clr_edges >= DEPTH});
            chk("req_ready2", {31'b0, bus2.req_ready}, {31'b0, clr_edges >= DEPTH});
            chk("busy1", {31'b0, bus1.busy}, {31'b0, clr_edges < DEPTH});
            chk("busy2", {31'b0, bus2.busy}, {31'b0, clr_edges < DEPTH});
            while (q1.size() > 0 && q1[0].due < edges) begin
                checks++; errors++;
                $display("FAIL missed_rsp1: got no response expected one at edge %0d", q1[0].due);
                void'(q1.pop_front());
            end
            while (q2.size() > 0 && q2[0].due < edges) begin
                checks++; errors++;
                $display("FAIL missed_rsp2: got no response expected one at edge %0d", q2[0].due);
                void'(q2.pop_front());
            end
            have1 = (q1.size() > 0 && q1[0].due == edges);
            have2 = (q2.size() > 0 && q2[0].due == edges);
            if (have1) h1 = q1.pop_front();
            if (have2) h2 = q2.pop_front();
            mon("lat1", bus1.rd_valid, bus1.rd_data, bus1.err, have1, h1, last1);
            mon("lat2", bus2.rd_valid, bus2.rd_data, bus2.err, have2, h2, last2);
        end
    end

    // Reference model: an accepted request updates the word array immediately; responses
    // become visible LAT-1 edges after the accepting edge.
    task automatic model_accept(input bit wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        bit          oor;
        logic [31:0] rdat;
        oor  = (a >= DEPTH);
        rdat = '0;
        if (wr) begin
            if (!oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[int'(a)][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else if (!oor) begin
            rdat = mem[int'(a)];
        end
        if (!wr || oor) begin
            q1.push_back('{due: edges,     rv: !wr, data: rdat, err: oor});
            q2.push_back('{due: edges + 1, rv: !wr, data: rdat, err: oor});
        end
    endtask

    task automatic drive(input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        bus1.req_valid = v;  bus2.req_valid = v;
        bus1.req_wr    = wr; bus2.req_wr    = wr;
        bus1.req_addr  = a;  bus2.req_addr  = a;
        bus1.req_wdata = d;  bus2.req_wdata = d;
        bus1.req_be    = be; bus2.req_be    = be;
    endtask

    task automatic issue(input bit v, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        drive(v, wr, a, d, be);
        @(posedge clk);
        #1;
        if (v && !rst && clr_edges > DEPTH) model_accept(wr, a, d, be);
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // Asserts rst mid-cycle so any in-flight response is dropped.
    task automatic do_reset(input int hold);
        rst = 1'b1;
        q1.delete();
        q2.delete();
        last1 = '0;
        last2 = '0;
        #1;
        chk("async_rd_valid1", {31'b0, bus1.rd_valid}, 32'd0);
        chk("async_rd_valid2", {31'b0, bus2.rd_valid}, 32'd0);
        chk("async_rd_data1", bus1.rd_data, 32'd0);
        chk("async_rd_data2", bus2.rd_data, 32'd0);
        chk("async_busy1", {31'b0, bus1.busy}, 32'd1);
        chk("async_ready2", {31'b0, bus2.req_ready}, 32'd0);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        zero_model();
    endtask

    task automatic wait_ready(input string nm, input bit v);
        int n;
        n = 0;
        while (!bus1.req_ready && n < 200) begin
            issue(v, 1'b0, 32'd7, 32'd0, 4'h0);
            n++;
        end
        chk(nm, n, DEPTH);
    endtask

    initial begin
        drive(1'b0, 1'b0, '0, '0, '0);
        zero_model();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        wait_ready("clear_cycles", 1'b0);
        issue(1, 0, 32'd5, 32'd0, 4'h0);
        issue(1, 1, 32'd3, 32'hDEADBEEF, 4'hF);
        issue(1, 0, 32'd3, 32'd0, 4'h0);
        issue(1, 1, 32'd3, 32'h11223344, 4'b0101);
        issue(1, 0, 32'd3, 32'd0, 4'h0);
        issue(1, 1, 32'd32, 32'h1, 4'hF);
        issue(1, 0, 32'd32, 32'd0, 4'h0);
        issue(1, 0, 32'd0, 32'd0, 4'h0);
        issue(1, 1, 32'h8000_0003, 32'hCAFEF00D, 4'hF);
        issue(1, 0, 32'h8000_0003, 32'd0, 4'h0);
        issue(1, 0, 32'd3, 32'd0, 4'h0);
        issue(1, 1, 32'd0, 32'd0, 4'h0);
        issue(0, 0, 32'd0, 32'd0, 4'h0);
        for (int i = 0; i < 4; i++) issue(1, 1, i, 32'd10 + i, 4'hF);
        for (int i = 0; i < 4; i++) issue(1, 0, i, 32'd0, 4'h0);
        repeat (3) issue(0, 0, 32'd0, 32'd0, 4'h0);

        for (int k = 0; k < 2000; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, DEPTH + 3);
            issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, $urandom,
                  4'($urandom_range(0, 15)));
        end

        issue(1, 1, 32'd9, 32'h0BADCAFE, 4'hF);
        issue(1, 0, 32'd9, 32'd0, 4'h0);
        issue(1, 0, 32'd9, 32'd0, 4'h0);
        drive(1'b1, 1'b0, 32'd9, 32'd0, 4'h0);
        do_reset(2);
        repeat (10) issue(1, 0, 32'd5, 32'd0, 4'h0);
        do_reset(2);
        wait_ready("reclear_cycles", 1'b1);
        issue(1, 0, 32'd9, 32'd0, 4'h0);
        for (int k = 0; k < 100; k++) begin
            issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, DEPTH + 1), $urandom, 4'($urandom_range(0, 15)));
        end
        repeat (4) issue(0, 0, 32'd0, 32'd0, 4'h0);
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0", q1.size(), q2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
